rand_range_gen: RTL and testbench
=================================

Name: rand_range_gen

Overview:
- Parametrised successor to the free-running 8-bit random source.
- Produces, on request, a uniformly distributed value in [0, LIMIT-1] by rejection sampling a maximal-length Fibonacci LFSR.
- Supports seed load and an optional UNIQUE mode that never repeats a value until cleared; used for mine placement.
- Sits between the game-setup FSM (requester) and the board RAM (consumer).

Parameters:
- WIDTH, 8, LFSR state width in bits.
- TAPS, 8'hB8, feedback mask; feedback = XOR-reduce(lfsr & TAPS).
- OUT_W, 6, output width; LIMIT must be <= 2^OUT_W and OUT_W <= WIDTH.
- LIMIT, 40, exclusive upper bound of output values.
- MAX_TRIES, 16, rejected candidates allowed per request before fallback.
- UNIQUE, 0, 1 enables the no-repeat bitmap of LIMIT bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- seed_load  in  1  load seed into the LFSR this edge.
- seed  in  WIDTH  seed value; a value of 0 is replaced by 1.
- clear_used  in  1  clear the UNIQUE bitmap.
- req  in  1  request a number; sampled only in IDLE.
- ack  in  1  consumer accepts number; meaningful only while valid=1.
- number  out  OUT_W  result, stable while valid=1.
- valid  out  1  result available.
- fallback  out  1  result came from the MAX_TRIES fallback path; qualified by valid.
- exhausted  out  1  UNIQUE mode with all LIMIT values used; qualified by valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - lfsr=1, state=IDLE, bitmap=0, try counter=0.
  - number=0, valid=0, fallback=0, exhausted=0, busy=0.
- LFSR:
  - Advances every cycle: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
  - seed_load overrides the advance: lfsr <= (seed==0) ? 1 : seed.
- seed_load priority:
  - seed_load is honoured in any state.
  - In IDLE, a req on the same edge is ignored.
  - In SEARCH, seed_load loads the LFSR but does not abort the request.
- Candidate: cand = lfsr[OUT_W-1:0], taken from the current register value.
- States: IDLE, SEARCH, VALID.
- IDLE:
  - req=1 and seed_load=0 -> SEARCH, tries=0.
  - If UNIQUE=1 and the popcount of used entries equals LIMIT: go directly to VALID instead, with exhausted=1 and number=0.
- SEARCH, one candidate per cycle:
  - accept if cand < LIMIT and (UNIQUE=0 or used[cand]=0);
  - on accept: number<=cand, valid<=1, used[cand]<=1 if UNIQUE, -> VALID.
  - on reject with tries == MAX_TRIES-1: fallback path.
    - UNIQUE=0: number <= lowest value < LIMIT, i.e. 0.
    - UNIQUE=1: number <= lowest unused index, which is then marked used.
    - Set fallback<=1, valid<=1, -> VALID.
  - otherwise tries<=tries+1 and stay in SEARCH.
- Latency: with the first candidate accepted, valid rises 2 edges after the req edge. Each rejection adds 1 cycle. Maximum latency is MAX_TRIES+1 edges.
- VALID:
  - valid, number, fallback and exhausted are held until ack=1.
  - On the ack edge: valid, fallback and exhausted are cleared, -> IDLE.
  - req is ignored in VALID.
- clear_used:
  - Zeroes the bitmap on that edge in any state.
  - If it coincides with an accept, the bitmap is zeroed; the clear wins over the set.
- The exhausted count is kept as a registered counter of used entries, 0..LIMIT. It increments on each mark and is zeroed by clear_used.
- busy = (state != IDLE).

Test Plan:
- Reset value check: assert rst_n=0 mid-SEARCH -> at the next edge valid=0, busy=0, number=0, and lfsr=1 (probe).
- Rejection path (LIMIT=40, OUT_W=6, UNIQUE=0): seed_load with seed=0x1C, then req=1 for 1 cycle.
  - SEARCH sees candidates 0x38(56) reject, 0x71->49 reject, 0xE2->34 accept.
  - Required: number=34, valid=1 four edges after the req edge, fallback=0.
- Zero seed: seed_load with seed=0, then req.
  - lfsr sequence 0x01->0x02, so first candidate=2.
  - Required: number=2, valid two edges after req.
- Handshake: hold ack=0 for 10 cycles -> valid and number stable. Pulse ack -> valid=0 next edge; a req in the VALID window is ignored, so no second result.
- UNIQUE=1, LIMIT=4, OUT_W=2: issue 4 req/ack pairs.
  - Required: four distinct values {0,1,2,3}.
  - 5th req -> valid with exhausted=1 and number=0.
  - Pulse clear_used, then req -> a normal result with exhausted=0.
- Fallback (MAX_TRIES=2, LIMIT=1, OUT_W=6): seed 0x1C.
  - Candidates 56 and 49 are both rejected.
  - Required: number=0, fallback=1, valid three edges after req.

Source files
------------

// File: rtl/rand_range_gen.sv
// rand_range_gen
//   Uniform random number source for game setup. A Fibonacci LFSR runs
//   freely. On a request the low OUT_W bits of the LFSR are taken as the
//   candidate, one per cycle, until one lands in [0, LIMIT-1]. A candidate
//   is also rejected if UNIQUE is set and that value was already handed out.
//   After MAX_TRIES rejected candidates a deterministic fallback value is
//   returned so that the latency stays bounded. In UNIQUE mode a LIMIT-bit
//   bitmap records the values handed out. Once every value is used, a
//   request completes at once with exhausted=1.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   seed_load   load seed into the LFSR this edge (zero seed becomes 1)
//   seed        seed value, WIDTH bits
//   clear_used  zero the used bitmap and used counter
//   req         request a number; sampled only when idle
//   ack         consumer accepts the current result
//   number      result, held while valid=1
//   valid       result available
//   fallback    result came from the bounded-retry fallback path
//   exhausted   UNIQUE mode and every value has been handed out
//   busy        request in progress or result not yet acknowledged

module rand_range_gen #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter int              OUT_W     = 6,
  parameter int              LIMIT     = 40,
  parameter int              MAX_TRIES = 16,
  parameter int              UNIQUE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             clear_used,
  input  logic             req,
  input  logic             ack,
  output logic [OUT_W-1:0] number,
  output logic             valid,
  output logic             fallback,
  output logic             exhausted,
  output logic             busy
);

  localparam int PAD   = 1 << OUT_W;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(LIMIT);
  localparam logic             UNIQUE_ON = (UNIQUE != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VALID  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] lfsr_reg;
  logic [TRY_W-1:0] tries_reg;
  logic [LIMIT-1:0] used_reg;
  logic [CNT_W-1:0] used_cnt_reg;

  logic [OUT_W-1:0] number_reg;
  logic             valid_reg;
  logic             fallback_reg;
  logic             exhausted_reg;

  // ------------------------------------------------------------------
  // Candidate qualification
  // ------------------------------------------------------------------
  logic [OUT_W-1:0] cand;
  logic             feedback;
  logic             accept;
  logic             last_try;
  logic             all_used;
  logic [OUT_W-1:0] low_idx;

  assign cand     = lfsr_reg[OUT_W-1:0];
  assign feedback = ^(lfsr_reg & TAPS);
  assign last_try = (tries_reg == LAST_TRY);
  assign all_used = (used_cnt_reg == LIMIT_CNT);

  // blocked[v] is 1 for every candidate value that must be rejected:
  // values at or above LIMIT always, and used values in UNIQUE mode.
  // Padding to the full 2^OUT_W range lets the candidate index it directly.
  logic [PAD-1:0] blocked;

  genvar gi;
  generate
    for (gi = 0; gi < PAD; gi++) begin : g_blocked
      if (gi < LIMIT) begin : g_in
        assign blocked[gi] = UNIQUE_ON & used_reg[gi];
      end else begin : g_out
        assign blocked[gi] = 1'b1;
      end
    end
  endgenerate

  assign accept = ~blocked[cand];

  // Lowest unused index, built as a ripple chain from the top entry down
  // so that the lowest clear bit wins.
  logic [OUT_W-1:0] low_chain [0:LIMIT];

  assign low_chain[LIMIT] = '0;
  generate
    for (gi = 0; gi < LIMIT; gi++) begin : g_low
      assign low_chain[gi] = used_reg[gi] ? low_chain[gi+1] : OUT_W'(gi);
    end
  endgenerate
  assign low_idx = low_chain[0];

  // ------------------------------------------------------------------
  // Control strobes (filled in by the output process)
  // ------------------------------------------------------------------
  logic             tries_clr;
  logic             tries_inc;
  logic             load_result;
  logic [OUT_W-1:0] res_number;
  logic             res_fallback;
  logic             res_exhausted;
  logic             clear_result;
  logic             mark_en;
  logic [OUT_W-1:0] mark_idx;
  logic [LIMIT-1:0] mark_vec;

  generate
    for (gi = 0; gi < LIMIT; gi++) begin : g_mark
      assign mark_vec[gi] = mark_en & (mark_idx == OUT_W'(gi));
    end
  endgenerate

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // A seed load on the same edge takes priority over a new request.
        if (req && !seed_load) begin
          if (UNIQUE_ON && all_used) begin
            state_next = ST_VALID;
          end else begin
            state_next = ST_SEARCH;
          end
        end
      end
      ST_SEARCH: begin
        if (accept || last_try) begin
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output / control logic
  // ------------------------------------------------------------------
  always_comb begin
    tries_clr     = 1'b0;
    tries_inc     = 1'b0;
    load_result   = 1'b0;
    res_number    = '0;
    res_fallback  = 1'b0;
    res_exhausted = 1'b0;
    clear_result  = 1'b0;
    mark_en       = 1'b0;
    mark_idx      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (req && !seed_load) begin
          tries_clr = 1'b1;
          if (UNIQUE_ON && all_used) begin
            load_result   = 1'b1;
            res_exhausted = 1'b1;
          end
        end
      end
      ST_SEARCH: begin
        if (accept) begin
          load_result = 1'b1;
          res_number  = cand;
          mark_en     = UNIQUE_ON;
          mark_idx    = cand;
        end else if (last_try) begin
          // Out of tries: return the lowest legal value. In UNIQUE mode that
          // is the lowest unused entry, which always exists here because the
          // exhausted case never enters SEARCH.
          load_result  = 1'b1;
          res_fallback = 1'b1;
          res_number   = UNIQUE_ON ? low_idx : '0;
          mark_en      = UNIQUE_ON;
          mark_idx     = low_idx;
        end else begin
          tries_inc = 1'b1;
        end
      end
      ST_VALID: begin
        if (ack) begin
          clear_result = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // LFSR: advances every cycle; a seed load overrides the advance.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_reg <= WIDTH'(1);
    end else if (seed_load) begin
      lfsr_reg <= (seed == '0) ? WIDTH'(1) : seed;
    end else begin
      lfsr_reg <= {lfsr_reg[WIDTH-2:0], feedback};
    end
  end

  // ------------------------------------------------------------------
  // Try counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tries_reg <= '0;
    end else if (tries_clr) begin
      tries_reg <= '0;
    end else if (tries_inc) begin
      tries_reg <= tries_reg + TRY_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Used bitmap and its population counter. A clear on the same edge as
  // a mark wins, so the freshly returned value is not remembered.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      used_reg     <= '0;
      used_cnt_reg <= '0;
    end else if (clear_used) begin
      used_reg     <= '0;
      used_cnt_reg <= '0;
    end else if (mark_en) begin
      used_reg     <= used_reg | mark_vec;
      used_cnt_reg <= used_cnt_reg + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Result registers: loaded on completion, held until acknowledged.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      number_reg    <= '0;
      valid_reg     <= 1'b0;
      fallback_reg  <= 1'b0;
      exhausted_reg <= 1'b0;
    end else if (load_result) begin
      number_reg    <= res_number;
      valid_reg     <= 1'b1;
      fallback_reg  <= res_fallback;
      exhausted_reg <= res_exhausted;
    end else if (clear_result) begin
      valid_reg     <= 1'b0;
      fallback_reg  <= 1'b0;
      exhausted_reg <= 1'b0;
    end
  end

  assign number    = number_reg;
  assign valid     = valid_reg;
  assign fallback  = fallback_reg;
  assign exhausted = exhausted_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rand_range_gen.sv
// Testbench for rand_range_gen. Three instances share one stimulus bus:
//   dut_a  LIMIT=40, OUT_W=6, MAX_TRIES=16, UNIQUE=0
//   dut_b  LIMIT=4,  OUT_W=2, MAX_TRIES=16, UNIQUE=1
//   dut_c  LIMIT=1,  OUT_W=6, MAX_TRIES=2,  UNIQUE=0
// sel_idx picks which instance's outputs a transaction is checked against.
module tb_rand_range_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, seed_load, clear_used, req, ack;
  logic [7:0] seed;

  logic [5:0] number_a, number_c;
  logic [1:0] number_b;
  logic valid_a, fallback_a, exhausted_a, busy_a;
  logic valid_b, fallback_b, exhausted_b, busy_b;
  logic valid_c, fallback_c, exhausted_c, busy_c;

  rand_range_gen #(.WIDTH(8), .TAPS(8'hB8), .OUT_W(6), .LIMIT(40), .MAX_TRIES(16), .UNIQUE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .clear_used(clear_used),
    .req(req), .ack(ack), .number(number_a), .valid(valid_a), .fallback(fallback_a),
    .exhausted(exhausted_a), .busy(busy_a));

  rand_range_gen #(.WIDTH(8), .TAPS(8'hB8), .OUT_W(2), .LIMIT(4), .MAX_TRIES(16), .UNIQUE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .clear_used(clear_used),
    .req(req), .ack(ack), .number(number_b), .valid(valid_b), .fallback(fallback_b),
    .exhausted(exhausted_b), .busy(busy_b));

  rand_range_gen #(.WIDTH(8), .TAPS(8'hB8), .OUT_W(6), .LIMIT(1), .MAX_TRIES(2), .UNIQUE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .clear_used(clear_used),
    .req(req), .ack(ack), .number(number_c), .valid(valid_c), .fallback(fallback_c),
    .exhausted(exhausted_c), .busy(busy_c));

  int checks   = 0;
  int failures = 0;
  int sel_idx  = 0;

  logic [7:0] obs_number;
  logic       obs_valid, obs_fb, obs_ex, obs_busy;
  logic       busy_any;

  always_comb begin
    obs_number = {2'b00, number_a};
    obs_valid  = valid_a;
    obs_fb     = fallback_a;
    obs_ex     = exhausted_a;
    obs_busy   = busy_a;
    if (sel_idx == 1) begin
      obs_number = {6'b000000, number_b};
      obs_valid  = valid_b;
      obs_fb     = fallback_b;
      obs_ex     = exhausted_b;
      obs_busy   = busy_b;
    end else if (sel_idx == 2) begin
      obs_number = {2'b00, number_c};
      obs_valid  = valid_c;
      obs_fb     = fallback_c;
      obs_ex     = exhausted_c;
      obs_busy   = busy_c;
    end
  end
  assign busy_any = busy_a | busy_b | busy_c;

  task automatic check(input string name, input int act, input int req_val);
    checks++;
    if (act != req_val) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req_val);
    end
  endtask

  // ---------------- reference model ----------------
  bit used_m [4];

  // Next LFSR value: shift left by one, bring in the parity of the tapped bits.
  function automatic int lfsr_step(input int x);
    int t;
    int ones;
    t = x & 'hB8;
    ones = 0;
    for (int b = 0; b < 8; b++) ones += (t >> b) & 1;
    return ((x * 2) % 256) + (ones % 2);
  endfunction

  // Predicts the outcome of "load seed, then request on the next cycle".
  task automatic predict(input int sel, input int sd, output int num, output int lat,
                         output bit fb, output bit ex);
    int  outw, limit, maxt, s, cand, n_used;
    bit  uniq, done;
    outw  = (sel == 1) ? 2 : 6;
    limit = (sel == 0) ? 40 : ((sel == 1) ? 4 : 1);
    maxt  = (sel == 2) ? 2 : 16;
    uniq  = (sel == 1);
    num = 0; lat = 0; fb = 0; ex = 0; done = 0;
    n_used = 0;
    if (uniq) for (int i = 0; i < 4; i++) n_used += used_m[i];
    if (uniq && n_used == limit) begin
      ex = 1; lat = 1; done = 1;
    end
    // The LFSR steps once on the request edge, so the first candidate
    // comes from the value after one step from the loaded seed.
    s = (sd == 0) ? 1 : sd;
    s = lfsr_step(s);
    for (int k = 0; k < maxt && !done; k++) begin
      cand = s % (1 << outw);
      if (cand < limit && !(uniq && used_m[cand])) begin
        num = cand; lat = k + 2; done = 1;
        if (uniq) used_m[cand] = 1;
      end
      s = lfsr_step(s);
    end
    if (!done) begin
      fb = 1; lat = maxt + 1; num = 0;
      if (uniq) begin
        for (int i = limit - 1; i >= 0; i--) if (!used_m[i]) num = i;
        used_m[num] = 1;
      end
    end
  endtask

  // One full transaction: load seed, request, measure latency, hold, ack.
  task automatic do_req(input string tag, input int sel, input logic [7:0] sd, input int hold,
                        input bit poke_req, input int exp_num, input int exp_lat,
                        input bit exp_fb, input bit exp_ex, output int got_num);
    int lat;
    sel_idx = sel;
    @(negedge clk); seed = sd; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0; req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk); req = 1'b0; lat++;
    end while (!obs_valid && lat < 40);
    got_num = int'(obs_number);
    $display("txn %s sel=%0d seed=0x%02h number=%0d latency=%0d fallback=%0d exhausted=%0d",
             tag, sel, sd, obs_number, lat, obs_fb, obs_ex);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_number"}, int'(obs_number), exp_num);
    check({tag, "_fallback"}, int'(obs_fb), int'(exp_fb));
    check({tag, "_exhausted"}, int'(obs_ex), int'(exp_ex));
    for (int i = 0; i < hold; i++) begin
      if (poke_req) req = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, int'(obs_valid), 1);
      check({tag, "_hold_number"}, int'(obs_number), exp_num);
    end
    req = 1'b0; ack = 1'b1;
    @(negedge clk);
    check({tag, "_ack_valid"}, int'(obs_valid), 0);
    check({tag, "_ack_busy"}, int'(obs_busy), 0);
    for (int i = 0; i < 40 && busy_any; i++) @(negedge clk);
    ack = 1'b0;
    check({tag, "_drain"}, int'(busy_any), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_no_second"}, int'(obs_valid), 0);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_used = 1'b1;
    @(negedge clk); clear_used = 1'b0;
    for (int i = 0; i < 4; i++) used_m[i] = 0;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] sd;
    int         num;
    int         lat;
    bit         fb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got, e_num, e_lat, seen, sel;
    bit e_fb, e_ex;
    logic [7:0] sd;

    // Hand-derived vectors: {instance, seed, number, latency, fallback}
    vecs[0] = '{0, 8'h1C, 34, 4, 1'b0};
    vecs[1] = '{0, 8'h00,  2, 2, 1'b0};
    vecs[2] = '{0, 8'h05, 10, 2, 1'b0};
    vecs[3] = '{0, 8'h80,  1, 2, 1'b0};
    vecs[4] = '{0, 8'hFF, 33, 6, 1'b0};
    vecs[5] = '{2, 8'h1C,  0, 3, 1'b1};
    vecs[6] = '{2, 8'h05,  0, 3, 1'b1};
    vecs[7] = '{2, 8'h40,  0, 2, 1'b0};

    rst_n = 1'b0; seed_load = 1'b0; clear_used = 1'b0; req = 1'b0; ack = 1'b0; seed = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_number_a", int'(number_a), 0);
    check("rst_fallback_a", int'(fallback_a), 0);
    check("rst_exhausted_b", int'(exhausted_b), 0);
    check("rst_valid_b", int'(valid_b), 0);
    check("rst_lfsr_a", int'(dut_a.lfsr_reg), 1);
    rst_n = 1'b1;

    // Reset asserted in the middle of a search
    sel_idx = 0;
    @(negedge clk); seed = 8'hFF; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("midsearch_busy", int'(busy_a), 1);
    rst_n = 1'b0;
    @(negedge clk);
    $display("txn midsearch_reset valid=%0d busy=%0d number=%0d lfsr=0x%02h",
             valid_a, busy_a, number_a, dut_a.lfsr_reg);
    check("midrst_valid", int'(valid_a), 0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_number", int'(number_a), 0);
    check("midrst_lfsr", int'(dut_a.lfsr_reg), 1);
    rst_n = 1'b1;

    // Table vectors; the first one is the long handshake with req poked in VALID
    for (int i = 0; i < 8; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].sel, vecs[i].sd,
             (i == 0) ? 10 : $urandom_range(0, 3), (i == 0),
             vecs[i].num, vecs[i].lat, vecs[i].fb, 1'b0, got);
    end

    // Randomized seeds on the non-unique instances against the model
    for (int i = 0; i < 12; i++) begin
      sel = ($urandom_range(0, 1) == 0) ? 0 : 2;
      sd  = 8'($urandom);
      predict(sel, int'(sd), e_num, e_lat, e_fb, e_ex);
      do_req($sformatf("rnd%0d", i), sel, sd, $urandom_range(0, 3), 1'b0,
             e_num, e_lat, e_fb, e_ex, got);
    end

    // UNIQUE instance: two rounds of four distinct values, then exhaustion
    for (int round = 0; round < 2; round++) begin
      pulse_clear();
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        sd = 8'($urandom);
        predict(1, int'(sd), e_num, e_lat, e_fb, e_ex);
        do_req($sformatf("uniq%0d_%0d", round, i), 1, sd, $urandom_range(0, 2), 1'b0,
               e_num, e_lat, e_fb, e_ex, got);
        if (i < 4) seen = seen | (1 << got);
      end
      check($sformatf("uniq%0d_distinct", round), seen, 'hF);
    end

    // After clearing, an exhausted instance hands out a normal result again
    pulse_clear();
    sd = 8'h1C;
    predict(1, int'(sd), e_num, e_lat, e_fb, e_ex);
    do_req("uniq_after_clear", 1, sd, 1, 1'b0, e_num, e_lat, e_fb, e_ex, got);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
